uart_led_control: RTL and testbench

//   UART receiver front end of the car controller: samples the asynchronous serial

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_led_control_if.sv | 11 +
 rtl/uart_rx_core.sv | 114 +++++++++++
 rtl/uart_led_control.sv | 36 +++
 tb/tb_uart_led_control.sv | 137 +++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 125_000_000;
    localparam int unsigned DEF_BAUD     = 4800;
    localparam int unsigned DATA_BITS    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } uart_state_e;

endpackage

// File: rtl/uart_led_control_if.sv
// Serial pin and LED bus between the pad/board side and the receiver.
interface uart_led_control_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] LED;

    modport master (output rx, input LED);
    modport slave  (input rx, output LED);

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: rx synchronizer, framing FSM, one-cycle valid per good frame.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_meta_q, rxs_q;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 valid_d, valid_q;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: start is re-checked at half a bit so every later sample lands mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxs_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == IDX_LAST) state_d = StStop;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                // A break or framing error holds here until the line returns high.
                cnt_d = '0;
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign data  = shift_q;
    assign valid = valid_q;

endmodule

// File: rtl/uart_led_control.sv
// Top: latches each correctly framed byte from the receiver onto LED.
module uart_led_control
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic               clk,
    input  logic               reset,
    uart_led_control_if.slave  bus
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] led_q;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx_core (
        .clk   (clk),
        .reset (reset),
        .rx    (bus.rx),
        .data  (rx_data),
        .valid (rx_valid)
    );

    // LED holds the last good byte; only a valid stop bit changes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        led_q <= '0;
        else if (rx_valid) led_q <= rx_data;
    end

    assign bus.LED = led_q;

endmodule

// File: tb/tb_uart_led_control.sv
// Directed bench for uart_led_control with a shortened bit period (64 clocks).
module tb_uart_led_control;

    localparam int unsigned CLK_FREQ = 125_000_000;
    localparam int unsigned BAUD     = 1_953_125;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_led_control_if bus ();

    uart_led_control #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned clks;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: LED=%02h expected %02h", name, act, exp);
        end
    endtask

    // Drives one frame on negedges; returns exactly 10 bit periods after the start edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned clks);
        bus.rx = 1'b0;
        wait_clks(clks);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_clks(clks);
        end
        bus.rx = stop;
        wait_clks(clks);
        bus.rx = 1'b1;
    endtask

    initial begin
        vecs[0] = '{data: 8'hEB, stop: 1'b0, clks: CPB,     exp: 8'h00};
        vecs[1] = '{data: 8'hEB, stop: 1'b1, clks: CPB,     exp: 8'hEB};
        vecs[2] = '{data: 8'h12, stop: 1'b1, clks: CPB - 1, exp: 8'h12};
        vecs[3] = '{data: 8'hC4, stop: 1'b1, clks: CPB + 1, exp: 8'hC4};
        vecs[4] = '{data: 8'h00, stop: 1'b1, clks: CPB,     exp: 8'h00};
        vecs[5] = '{data: 8'hFF, stop: 1'b0, clks: CPB,     exp: 8'h00};

        bus.rx = 1'b1;
        #10;
        check("reset_led", bus.LED, 8'h00);
        #10 reset = 1'b1;
        wait_clks(4 * CPB);
        check("idle_after_reset", bus.LED, 8'h00);

        // Table: framing error, good frames, +/- bit-period skew.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].clks);
            check($sformatf("vec%0d_end", v), bus.LED, vecs[v].exp);
            wait_clks(2 * CPB);
            check($sformatf("vec%0d_stable", v), bus.LED, vecs[v].exp);
        end

        // Back-to-back frames with no idle gap.
        send_frame(8'h55, 1'b1, CPB);
        check("b2b_first", bus.LED, 8'h55);
        send_frame(8'hA3, 1'b1, CPB);
        check("b2b_second", bus.LED, 8'hA3);
        wait_clks(2 * CPB);

        // Short low pulse while idle must be rejected.
        bus.rx = 1'b0;
        wait_clks(CPB / 4);
        bus.rx = 1'b1;
        wait_clks(3 * CPB);
        check("glitch_rejected", bus.LED, 8'hA3);
        send_frame(8'h96, 1'b1, CPB);
        check("after_glitch", bus.LED, 8'h96);
        wait_clks(2 * CPB);

        // Reset mid-frame (data bit 4 of 0x3C) clears LED asynchronously.
        bus.rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 8'h3C >> i;
            wait_clks(CPB);
        end
        bus.rx = 1'b1;
        wait_clks(CPB / 2);
        #2 reset = 1'b0;
        #1 check("async_reset", bus.LED, 8'h00);
        wait_clks(10);
        check("held_in_reset", bus.LED, 8'h00);
        reset = 1'b1;
        wait_clks(2 * CPB);
        send_frame(8'h81, 1'b1, CPB);
        check("after_reset_frame", bus.LED, 8'h81);
        wait_clks(2 * CPB);

        // Break: line low for 20 bit periods never updates LED.
        bus.rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clks(5 * CPB);
            check($sformatf("break_%0d", i), bus.LED, 8'h81);
        end
        bus.rx = 1'b1;
        wait_clks(2 * CPB);
        check("break_release", bus.LED, 8'h81);
        send_frame(8'h7E, 1'b1, CPB);
        check("after_break", bus.LED, 8'h7E);
        wait_clks(CPB);
        check("after_break_stable", bus.LED, 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
